// File: rtl/lfsr_msg_encryptor.sv
// Pads a message from data memory with leading '_' bytes and XORs it with a 6-bit LFSR into mem[64:127].
// Latency: done 133 edges after the start edge; no backpressure, memory is assumed ready every cycle.
module lfsr_msg_encryptor #(
    parameter int         MSG_MAX  = 50,
    parameter logic [7:0] CFG_BASE = 8'd61,
    parameter logic [7:0] OUT_BASE = 8'd64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic [7:0] mem_rdata,
    output logic [7:0] mem_raddr,
    output logic       mem_wr_en,
    output logic [7:0] mem_waddr,
    output logic [7:0] mem_wdata,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] MSG_MAX_B = 8'(MSG_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CFG  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cfg_cnt_q;
    logic [5:0] idx_q;
    logic       phase_q;
    logic [5:0] lfsr_q;
    logic [5:0] taps_q;
    logic [3:0] pre_len_q;
    logic       done_q;

    logic [7:0] msg_addr;
    logic       rd_hit;
    logic [7:0] padded;

    function automatic logic [5:0] tap_sel(input logic [7:0] sel);
        case (sel)
            8'd0:    tap_sel = 6'h21;
            8'd1:    tap_sel = 6'h2D;
            8'd2:    tap_sel = 6'h30;
            8'd3:    tap_sel = 6'h33;
            8'd4:    tap_sel = 6'h36;
            8'd5:    tap_sel = 6'h39;
            default: tap_sel = 6'h33;
        endcase
    endfunction

    // Byte i carries message byte (i - pre_len) when that lands inside the message, else '_'.
    assign msg_addr = {2'b00, idx_q} - {4'b0000, pre_len_q};
    assign rd_hit   = ({2'b00, idx_q} >= {4'b0000, pre_len_q}) && (msg_addr < MSG_MAX_B);
    assign padded   = rd_hit ? mem_rdata : 8'h5F;
    assign done     = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_raddr = 8'h00;
        mem_wr_en = 1'b0;
        mem_waddr = 8'h00;
        mem_wdata = 8'h00;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!init) state_d = S_CFG;
            end
            S_CFG: begin
                busy = 1'b1;
                if (cfg_cnt_q != 2'd3) mem_raddr = CFG_BASE + {6'b000000, cfg_cnt_q};
                else                   state_d   = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (!phase_q) begin
                    if (rd_hit) mem_raddr = msg_addr;
                end else begin
                    mem_wr_en = 1'b1;
                    mem_waddr = OUT_BASE + {2'b00, idx_q};
                    mem_wdata = padded ^ {2'b00, lfsr_q};
                    if (idx_q == 6'd63) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (init) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_cnt_q <= 2'd0;
            idx_q     <= 6'd0;
            phase_q   <= 1'b0;
            lfsr_q    <= 6'd0;
            taps_q    <= 6'd0;
            pre_len_q <= 4'd0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == S_DONE) && !init;
            case (state_q)
                S_IDLE: begin
                    cfg_cnt_q <= 2'd0;
                    idx_q     <= 6'd0;
                    phase_q   <= 1'b0;
                    lfsr_q    <= 6'd0;
                    taps_q    <= 6'd0;
                    pre_len_q <= 4'd0;
                end
                S_CFG: begin
                    // Read data trails its address by one cycle, so capture lags the issue slot.
                    cfg_cnt_q <= cfg_cnt_q + 2'd1;
                    case (cfg_cnt_q)
                        2'd1: pre_len_q <= (mem_rdata < 8'd7 || mem_rdata > 8'd12) ? 4'd7 : mem_rdata[3:0];
                        2'd2: taps_q    <= tap_sel(mem_rdata);
                        2'd3: lfsr_q    <= (mem_rdata[5:0] == 6'd0) ? 6'h01 : mem_rdata[5:0];
                        default: ;
                    endcase
                end
                S_RUN: begin
                    phase_q <= ~phase_q;
                    if (phase_q) begin
                        idx_q  <= idx_q + 6'd1;
                        lfsr_q <= {lfsr_q[4:0], ^(lfsr_q & taps_q)};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
